data_bus_arbiter: RTL

Two-port arbiter that shares one `DataBus` slave (data memory or cache) between two `DataBus` masters: port 0 is the pipeline load/store unit, port 1 is the secondary master (debug module or DMA). It sits between the masters and the memory-side `DataBus` and grants the bus per transaction. A grant is held until the memory completes the access. The ungranted master is stalled through its `busy` signal.

---
 rtl/data_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// Two-port DataBus arbiter: LSU (port 0) and debug/DMA (port 1) share one memory port.
// Define DATA_BUS_ARBITER_RR_EN for round-robin arbitration; the default build is fixed priority to port 0.

package data_bus_arbiter_pkg;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ACCESS_W = 2;

    typedef logic [ADDR_W-1:0]   data_addr_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ACCESS_W-1:0] data_access_t;

    typedef struct packed {
        data_addr_t   addr;
        data_access_t access;
        data_t        wdata;
        logic         re;
        logic         we;
    } bus_req_t;
endpackage

module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset,
    input  data_addr_t   m0_addr,
    input  data_access_t m0_access,
    input  data_t        m0_wdata,
    input  logic         m0_re,
    input  logic         m0_we,
    output data_t        m0_rdata,
    output logic         m0_busy,
    input  data_addr_t   m1_addr,
    input  data_access_t m1_access,
    input  data_t        m1_wdata,
    input  logic         m1_re,
    input  logic         m1_we,
    output data_t        m1_rdata,
    output logic         m1_busy,
    output data_addr_t   mem_addr,
    output data_access_t mem_access,
    output data_t        mem_wdata,
    output logic         mem_re,
    output logic         mem_we,
    input  data_t        mem_rdata,
    input  logic         mem_busy,
    output logic [1:0]   o_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t   state;
    state_t   next_state;
    logic     req0;
    logic     req1;
    logic     done0;
    logic     done1;
    logic     pick1;
    logic     pass0;
    bus_req_t bus0;
    bus_req_t bus1;
    bus_req_t bus_mem;

    assign bus0 = '{addr: m0_addr, access: m0_access, wdata: m0_wdata, re: m0_re, we: m0_we};
    assign bus1 = '{addr: m1_addr, access: m1_access, wdata: m1_wdata, re: m1_re, we: m1_we};

    assign req0 = m0_re | m0_we;
    assign req1 = m1_re | m1_we;

    // Owner leaves its grant when the access completes or it withdraws the request
    assign done0 = ~req0 | ~mem_busy;
    assign done1 = ~req1 | ~mem_busy;

`ifdef DATA_BUS_ARBITER_RR_EN
    logic last;

    assign pick1 = ~last;
    assign pass0 = req1;

    // Remember the most recent grantee so a contest goes to the other port
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last <= 1'b1;
        end else if (next_state != state) begin
            if (next_state == GNT0) begin
                last <= 1'b0;
            end else if (next_state == GNT1) begin
                last <= 1'b1;
            end
        end
    end
`else
    assign pick1 = 1'b0;
    assign pass0 = 1'b0;
`endif

    always_comb begin
        next_state = state;
        bus_mem    = '0;
        m0_busy    = req0;
        m1_busy    = req1;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = pick1 ? GNT1 : GNT0;
                end else if (req0) begin
                    next_state = GNT0;
                end else if (req1) begin
                    next_state = GNT1;
                end
            end
            GNT0: begin
                bus_mem = bus0;
                m0_busy = req0 & mem_busy;
                if (done0) begin
                    next_state = pass0 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                bus_mem = bus1;
                m1_busy = req1 & mem_busy;
                // A waiting port 0 takes over directly in both arbitration modes
                if (done1) begin
                    next_state = req0 ? GNT0 : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign mem_addr   = bus_mem.addr;
    assign mem_access = bus_mem.access;
    assign mem_wdata  = bus_mem.wdata;
    assign mem_re     = bus_mem.re;
    assign mem_we     = bus_mem.we;

    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            o_owner <= 2'b00;
        end else begin
            state   <= next_state;
            o_owner <= {next_state == GNT1, next_state == GNT0};
        end
    end

endmodule
